// File: rtl/cacheline_adaptor.sv
// rtl/cacheline_adaptor.sv - 256-bit cache line to 4-beat 64-bit burst memory bridge
// Optional feature: define CACHELINE_ADAPTOR_ALIGN_EN to force address_o[4:0] to zero.
module cacheline_adaptor #(
  parameter int BEATS = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [64*BEATS-1:0]   line_i,
  output logic [64*BEATS-1:0]   line_o,
  input  logic [31:0]           address_i,
  input  logic                  read_i,
  input  logic                  write_i,
  output logic                  resp_o,
  input  logic [63:0]           burst_i,
  output logic [63:0]           burst_o,
  output logic [31:0]           address_o,
  output logic                  read_o,
  output logic                  write_o,
  input  logic                  resp_i
);

  localparam int LW = 64 * BEATS;
  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     addr_q, addr_d;
  logic [LW-1:0]   wbuf_q, wbuf_d;
  logic [LW-1:0]   line_q, line_d;
  logic [63:0]     burst_q, burst_d;
  logic            read_q, read_d;
  logic            write_q, write_d;
  logic            resp_q, resp_d;
  logic            last_beat;
  logic [31:0]     addr_in;

  assign last_beat = (cnt_q == CW'(BEATS - 1));

`ifdef CACHELINE_ADAPTOR_ALIGN_EN
  // Memory only ever sees line-aligned addresses; the low bits are dropped at capture.
  assign addr_in = {address_i[31:5], 5'b0};
`else
  assign addr_in = address_i;
`endif

  // Next-state, datapath and registered-output decode for the transfer FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wbuf_d  = wbuf_q;
    line_d  = line_q;
    case (state_q)
      IDLE: begin
        // Write-back takes priority so a dirty victim is never lost behind a refill.
        if (write_i) begin
          addr_d  = addr_in;
          wbuf_d  = line_i;
          cnt_d   = '0;
          state_d = WRITE;
        end else if (read_i) begin
          addr_d  = addr_in;
          cnt_d   = '0;
          state_d = READ;
        end
      end
      READ: begin
        if (resp_i) begin
          line_d[{cnt_q, 6'b0} +: 64] = burst_i;
          cnt_d = cnt_q + 1'b1;
          if (last_beat) state_d = DONE;
        end
      end
      WRITE: begin
        if (resp_i) begin
          cnt_d = cnt_q + 1'b1;
          if (last_beat) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    read_d  = (state_d == READ);
    write_d = (state_d == WRITE);
    resp_d  = (state_d == DONE);
    burst_d = (state_d == WRITE) ? wbuf_d[{cnt_d, 6'b0} +: 64] : 64'b0;
  end

  // State and output registers; reset aborts any burst in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wbuf_q  <= '0;
      line_q  <= '0;
      burst_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wbuf_q  <= wbuf_d;
      line_q  <= line_d;
      burst_q <= burst_d;
      read_q  <= read_d;
      write_q <= write_d;
      resp_q  <= resp_d;
    end
  end

  assign line_o    = line_q;
  assign burst_o   = burst_q;
  assign address_o = addr_q;
  assign read_o    = read_q;
  assign write_o   = write_q;
  assign resp_o    = resp_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb/tb_cacheline_adaptor.sv - directed table-driven bench for cacheline_adaptor
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int tests = 0;
  int fails = 0;

  cacheline_adaptor #(.BEATS(4)) dut (
    .clk(clk), .reset_n(reset_n), .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] B1 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] B2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] B3 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] B4 = 64'h4444_4444_4444_4444;
  localparam logic [63:0] WA = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] WB = 64'hBBBB_BBBB_BBBB_BBBB;
  localparam logic [63:0] WC = 64'hCCCC_CCCC_CCCC_CCCC;
  localparam logic [63:0] WD = 64'hDDDD_DDDD_DDDD_DDDD;
  localparam logic [255:0] RL  = {B4, B3, B2, B1};
  localparam logic [255:0] WL  = {WD, WC, WB, WA};
  localparam logic [255:0] WL2 = {WA, WB, WC, WD};

  typedef struct {
    logic         rd, wr, rsp;
    logic [63:0]  burst;
    logic [255:0] line;
    logic [31:0]  addr;
    logic         e_rd, e_wr, e_resp;
    logic         ck_b;
    logic [63:0]  e_burst;
    logic         ck_l;
    logic [255:0] e_line;
    logic         ck_a;
    logic [31:0]  e_addr;
  } vec_t;

  vec_t vq[$];

  function automatic logic [31:0] exp_addr(input logic [31:0] a);
`ifdef CACHELINE_ADAPTOR_ALIGN_EN
    return {a[31:5], 5'b0};
`else
    return a;
`endif
  endfunction

  function automatic vec_t mk(
    input logic rd, wr, rsp, input logic [63:0] b, input logic [255:0] l, input logic [31:0] a,
    input logic e_rd, e_wr, e_resp, input logic ck_b, input logic [63:0] e_b,
    input logic ck_l, input logic [255:0] e_l, input logic ck_a, input logic [31:0] e_a);
    vec_t v;
    v.rd = rd; v.wr = wr; v.rsp = rsp; v.burst = b; v.line = l; v.addr = a;
    v.e_rd = e_rd; v.e_wr = e_wr; v.e_resp = e_resp;
    v.ck_b = ck_b; v.e_burst = e_b; v.ck_l = ck_l; v.e_line = e_l;
    v.ck_a = ck_a; v.e_addr = e_a;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step(input logic rd, wr, rsp, input logic [63:0] b,
                      input logic [255:0] l, input logic [31:0] a);
    read_i = rd; write_i = wr; resp_i = rsp; burst_i = b; line_i = l; address_i = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0]  ea1, ea2, ea3;
    logic [63:0]  gb [4];
    logic [255:0] gl;
    int           pat [7];
    int           j;

    ea1 = exp_addr(32'h0000_1234);
    ea2 = exp_addr(32'h0000_2008);
    ea3 = exp_addr(32'h0000_3010);

    // Line read with consecutive beats; address_i change mid-burst must be ignored.
    vq.push_back(mk(1,0,0, 64'h0, '0, 32'h1234,     1,0,0, 0,64'h0, 0,'0, 1,ea1));
    vq.push_back(mk(1,0,1, B1,    '0, 32'h9999,     1,0,0, 0,64'h0, 0,'0, 1,ea1));
    vq.push_back(mk(1,0,1, B2,    '0, 32'h9999,     1,0,0, 0,64'h0, 0,'0, 1,ea1));
    vq.push_back(mk(1,0,1, B3,    '0, 32'h9999,     1,0,0, 0,64'h0, 0,'0, 1,ea1));
    vq.push_back(mk(1,0,1, B4,    '0, 32'h9999,     0,0,1, 0,64'h0, 1,RL, 1,ea1));
    vq.push_back(mk(0,0,0, 64'h0, '0, 32'h0,        0,0,0, 0,64'h0, 1,RL, 0,32'h0));
    // Line write; line_i corrupted after capture must not leak into the burst.
    vq.push_back(mk(0,1,0, 64'h0, WL, 32'h2008,     0,1,0, 1,WA, 0,'0, 1,ea2));
    vq.push_back(mk(0,1,1, 64'h0, '0, 32'h0,        0,1,0, 1,WB, 0,'0, 1,ea2));
    vq.push_back(mk(0,1,1, 64'h0, '0, 32'h0,        0,1,0, 1,WC, 0,'0, 1,ea2));
    vq.push_back(mk(0,1,1, 64'h0, '0, 32'h0,        0,1,0, 1,WD, 0,'0, 1,ea2));
    vq.push_back(mk(0,1,1, 64'h0, '0, 32'h0,        0,0,1, 0,64'h0, 1,RL, 0,32'h0));
    vq.push_back(mk(0,0,0, 64'h0, '0, 32'h0,        0,0,0, 0,64'h0, 1,RL, 0,32'h0));
    // Stray memory strobes while idle.
    vq.push_back(mk(0,0,1, 64'hDEAD_BEEF_0BAD_F00D, '0, 32'h0, 0,0,0, 0,64'h0, 1,RL, 0,32'h0));
    vq.push_back(mk(0,0,1, 64'hFFFF_FFFF_FFFF_FFFF, '0, 32'h0, 0,0,0, 0,64'h0, 1,RL, 0,32'h0));
    // Simultaneous read and write: write wins, read_o never rises.
    vq.push_back(mk(1,1,0, 64'h0, WL2, 32'h3010,    0,1,0, 1,WD, 0,'0, 1,ea3));
    vq.push_back(mk(1,1,1, 64'h0, WL2, 32'h3010,    0,1,0, 1,WC, 0,'0, 1,ea3));
    vq.push_back(mk(1,1,1, 64'h0, WL2, 32'h3010,    0,1,0, 1,WB, 0,'0, 1,ea3));
    vq.push_back(mk(1,1,1, 64'h0, WL2, 32'h3010,    0,1,0, 1,WA, 0,'0, 1,ea3));
    vq.push_back(mk(1,1,1, 64'h0, WL2, 32'h3010,    0,0,1, 0,64'h0, 1,RL, 0,32'h0));
    vq.push_back(mk(0,0,0, 64'h0, '0,  32'h0,       0,0,0, 0,64'h0, 1,RL, 0,32'h0));

    // Asynchronous reset state.
    reset_n = 1'b0;
    read_i = 0; write_i = 0; resp_i = 0; burst_i = '0; line_i = '0; address_i = '0;
    #1;
    chk("rst_line_o",    line_o,    '0);
    chk("rst_burst_o",   burst_o,   '0);
    chk("rst_address_o", address_o, '0);
    chk("rst_ctl",       {read_o, write_o, resp_o}, '0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_ctl", {read_o, write_o, resp_o}, '0);

    foreach (vq[i]) begin
      step(vq[i].rd, vq[i].wr, vq[i].rsp, vq[i].burst, vq[i].line, vq[i].addr);
      chk($sformatf("v%0d_read_o", i),  read_o,  vq[i].e_rd);
      chk($sformatf("v%0d_write_o", i), write_o, vq[i].e_wr);
      chk($sformatf("v%0d_resp_o", i),  resp_o,  vq[i].e_resp);
      if (vq[i].ck_b) chk($sformatf("v%0d_burst_o", i),   burst_o,   vq[i].e_burst);
      if (vq[i].ck_l) chk($sformatf("v%0d_line_o", i),    line_o,    vq[i].e_line);
      if (vq[i].ck_a) chk($sformatf("v%0d_address_o", i), address_o, vq[i].e_addr);
    end

    // Gapped read: strobe pattern 1,0,0,1,1,0,1 with junk on idle beats.
    pat = '{1, 0, 0, 1, 1, 0, 1};
    gl = '0;
    for (int k = 0; k < 4; k++) begin
      gb[k] = {8{8'(8'hA0 + k)}};
      gl[64*k +: 64] = gb[k];
    end
    step(1, 0, 0, 64'h0, '0, 32'h0000_0047);
    chk("gap_start_read_o", read_o, 1'b1);
    chk("gap_address_o", address_o, exp_addr(32'h0000_0047));
    j = 0;
    for (int i = 0; i < 7; i++) begin
      if (pat[i] == 1) begin
        step(1, 0, 1, gb[j], '0, 32'h0);
        j++;
      end else begin
        step(1, 0, 0, 64'hFFFF_0000_FFFF_0000, '0, 32'h0);
      end
      if (i < 6) begin
        chk($sformatf("gap%0d_read_o", i), read_o, 1'b1);
        chk($sformatf("gap%0d_resp_o", i), resp_o, 1'b0);
      end
    end
    chk("gap_done_resp_o", resp_o, 1'b1);
    chk("gap_done_read_o", read_o, 1'b0);
    chk("gap_line_o", line_o, gl);
    step(0, 0, 0, 64'h0, '0, 32'h0);
    chk("gap_idle_resp_o", resp_o, 1'b0);
    chk("gap_hold_line_o", line_o, gl);

    // Reset after two write beats aborts without a response.
    step(0, 1, 0, 64'h0, WL, 32'h0000_5000);
    step(0, 1, 1, 64'h0, WL, 32'h0000_5000);
    step(0, 1, 1, 64'h0, WL, 32'h0000_5000);
    chk("abort_pre_write_o", write_o, 1'b1);
    chk("abort_pre_burst_o", burst_o, WC);
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_write_o", write_o, 1'b0);
    chk("abort_resp_o",  resp_o,  1'b0);
    chk("abort_burst_o", burst_o, 64'h0);
    write_i = 1'b0; resp_i = 1'b0;
    @(posedge clk); #1;
    chk("abort_hold_ctl", {read_o, write_o, resp_o}, '0);
    reset_n = 1'b1;
    step(1, 0, 0, 64'h0, '0, 32'h0000_0080);
    chk("post_read_o", read_o, 1'b1);
    gl = '0;
    for (int k = 0; k < 4; k++) begin
      gb[k] = {8{8'(8'h50 + k)}};
      gl[64*k +: 64] = gb[k];
      step(1, 0, 1, gb[k], '0, 32'h0);
    end
    chk("post_resp_o", resp_o, 1'b1);
    chk("post_line_o", line_o, gl);
    step(0, 0, 0, 64'h0, '0, 32'h0);
    chk("post_idle_ctl", {read_o, write_o, resp_o}, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
